i2c: RTL and testbench
======================

Name: i2c

Overview:
- Byte-level I2C master core with an open-drain SCL/SDA bus interface.
- Driven by a host FSM through parallel level inputs: prescale, control, transmit and command.
- Reports completion through status and receive.
- One command word performs an optional START, an optional write or read byte with its ACK bit, and an optional STOP. It sits between a sensor-sequencing FSM and the external bus (e.g. an MMA7455 accelerometer).

Parameters:
- PRESCALE_W, 16, width of the prescale input.

Ports:
- I2C_clk  input  1  system clock; all logic on the rising edge.
- arst_i  input  1  reset; synchronous, active-low (sampled on the I2C_clk rising edge despite the name).
- abort_i  input  1  synchronous active-high abort; positioned between clock and reset in the port order.
- prescale  input  PRESCALE_W  quarter-bit period minus 1, in clocks.
- control  input  8  bit7 EN (core enable); bit6 IEN (gates status[0]); others ignored.
- transmit  input  8  byte to send; also carries the slave address.
- receive  output  8  last byte read.
- command  input  8  bit7 STA, bit6 STO, bit5 RD, bit4 WR, bit3 ACK (0=ACK, 1=NACK on read), bit0 IACK; others ignored.
- status  output  8  bit7 TIP, bit6 BUSY, bit5 AL, bit1 RxACK, bit0 IF; bits 4:2 are 0.
- scl  inout  1  open-drain; drives 0 or z.
- sda  inout  1  open-drain; drives 0 or z.

Behaviour:
- Reset (arst_i=0 at a clock edge):
  - FSM idle; receive=0; status=0.
  - scl and sda released (z).
  - Internal last-command copy cmd_last=0.
- Abort (abort_i=1):
  - Same effect as reset, except receive is retained.
  - Abort takes priority over command launch.
- Disabled (EN=0):
  - Bus released; no launches; TIP=0.
  - cmd_last still tracks command.
- Launch rule:
  - cmd_last is registered from command every cycle.
  - launch = EN & idle & (command != cmd_last) & (command[7:4] != 0).
  - A command held constant never re-launches; the host changes command, or writes 0x00, to re-arm.
- status[7] TIP:
  - Combinational: tip_reg | launch.
  - Goes high in the same cycle a new command first appears, so a host polling one cycle after issuing sees TIP=1.
  - Falls the cycle after the final phase completes.
- Timing:
  - Each bit is 4 phases of (prescale+1) clocks.
  - SCL period = 4*(prescale+1) clocks; prescale=999 at 100 MHz gives 25 kHz.
- FSM states: IDLE, START(A–D), BIT(A–D) ×8, ACK(A–D), STOP(A–D).
- Sequence for a launched command:
  - If STA: START, then BUSY=1.
  - If WR or RD: 8 data bits MSB first, then the ACK bit.
  - If STO: STOP, then BUSY=0.
  - Then IDLE, with IF=1 when IEN=1.
  - WR and RD both set: WR wins.
- START: SDA released, SCL released; SDA low; SCL low.
- STOP: SDA low, SCL released; SDA released.
- Data bit:
  - SDA set while SCL is low.
  - SCL high for phases B–C; read data sampled in phase C.
- WR: drive transmit[7:0] (latched at launch); at the ACK bit, release SDA and sample it into RxACK.
- RD:
  - Release SDA and shift the samples in.
  - receive is updated once, at the end of the 8th bit.
  - At the ACK bit, drive SDA to command[3] (latched at launch).
- Arbitration loss (AL):
  - Condition: SDA reads 0 while the master releases it during a write/START data phase.
  - Effect: AL=1, bus released, BUSY=0, TIP cleared.
  - AL is cleared at the next launch.
- IACK=1 clears IF.
- Repeated START (STA while BUSY=1) is legal: release SDA first, then run the START phases.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined: in any phase where the master releases SCL, the phase counter holds until scl reads 1 (slave clock stretching).
- Undefined: SCL is never read back and phases advance purely on the prescale counter.

Test Plan:
- Reset: arst_i=0 for 2 clocks -> status=0x00, receive=0x00, scl=z, sda=z.
- Issue command=0x90, transmit=0x3A, prescale=3, EN=1, slave model ACKs:
  - status[7]=1 in the same cycle command changes.
  - SCL period 16 clocks.
  - SDA bits 0,0,1,1,1,0,1,0 after START.
  - TIP=0 after the ACK bit; BUSY=1; RxACK=0.
- Hold command=0x90 after completion -> no relaunch, TIP stays 0. Change to command=0x10, transmit=0x16 -> launches with no START.
- command=0x50, transmit=0x05 -> byte sent then STOP (SDA rises while SCL high); BUSY=0.
- Slave returns 0xA5 on command=0x28 (RD+NACK) -> receive=0xA5, master SDA released at the ACK bit, TIP low afterwards.
- abort_i=1 mid-byte -> scl/sda released next cycle, TIP=0, BUSY=0, receive unchanged.

Source files
------------

// File: rtl/i2c.sv
// -----------------------------------------------------------------------------
// i2c -- byte-level I2C master with open-drain SCL/SDA.
//
// A host FSM drives level inputs. A new, non-zero command word runs an
// optional START, an optional 8-bit write or read with its ACK bit, and an
// optional STOP. Completion is reported through status and receive.
//
// Ports:
//   I2C_clk   system clock; all logic on the rising edge
//   abort_i   synchronous abort, active high. Acts like reset, but keeps receive.
//   arst_i    synchronous reset, active low (sampled on I2C_clk)
//   prescale  quarter-bit period minus 1, in I2C_clk cycles
//   control   [7] EN core enable, [6] IEN interrupt-flag enable
//   transmit  byte to send, including the slave address byte
//   receive   last byte read
//   command   [7] STA, [6] STO, [5] RD, [4] WR, [3] ACK (1 = NACK), [0] IACK
//   status    [7] TIP, [6] BUSY, [5] AL, [1] RxACK, [0] IF
//   scl, sda  open-drain bus lines; each drives 0 or z
//
// Optional build macro: I2C_CLOCK_STRETCH_EN. When it is defined, a phase
// in which the master releases SCL is held until SCL reads 1.
//
// Handshake: there is no valid/ready pair. A command is accepted when it
// differs from the value sampled in the previous cycle and has any of
// STA/STO/RD/WR set, while the core is enabled and idle. TIP is the busy
// indication. To issue the same command again, the host must write a
// different value (for example 0x00) first.
// -----------------------------------------------------------------------------
module i2c #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  I2C_clk,
  input  logic                  abort_i,
  input  logic                  arst_i,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            control,
  input  logic [7:0]            transmit,
  output logic [7:0]            receive,
  input  logic [7:0]            command,
  output logic [7:0]            status,
  inout  wire                   scl,
  inout  wire                   sda
);

  localparam logic [4:0] S_IDLE  = 5'd0;
  localparam logic [4:0] S_STA_A = 5'd1;
  localparam logic [4:0] S_STA_B = 5'd2;
  localparam logic [4:0] S_STA_C = 5'd3;
  localparam logic [4:0] S_STA_D = 5'd4;
  localparam logic [4:0] S_BIT_A = 5'd5;
  localparam logic [4:0] S_BIT_B = 5'd6;
  localparam logic [4:0] S_BIT_C = 5'd7;
  localparam logic [4:0] S_BIT_D = 5'd8;
  localparam logic [4:0] S_ACK_A = 5'd9;
  localparam logic [4:0] S_ACK_B = 5'd10;
  localparam logic [4:0] S_ACK_C = 5'd11;
  localparam logic [4:0] S_ACK_D = 5'd12;
  localparam logic [4:0] S_STO_A = 5'd13;
  localparam logic [4:0] S_STO_B = 5'd14;
  localparam logic [4:0] S_STO_C = 5'd15;
  localparam logic [4:0] S_STO_D = 5'd16;

  logic [4:0]            state;
  logic [PRESCALE_W-1:0] cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            sh;
  logic [7:0]            cmd_last;
  logic                  c_sto, c_rd, c_wr, c_ack;
  logic                  tip_reg, busy, al, rxack, if_flag;
  logic                  scl_lo, sda_lo;      // registered open-drain pull-downs
  logic                  scl_lo_n, sda_lo_n;
  logic                  en, ien, launch, stretch_ok, phase_end, lose, finish;
  logic                  unused_ok;

  assign en  = control[7];
  assign ien = control[6];

  assign launch = arst_i & ~abort_i & en & (state == S_IDLE) &
                  (command != cmd_last) & (|command[7:4]);

  // TIP includes launch so that the host sees it in the same cycle.
  assign status = {tip_reg | launch, busy, al, 3'b000, rxack, if_flag};

  assign scl = scl_lo ? 1'b0 : 1'bz;
  assign sda = sda_lo ? 1'b0 : 1'bz;

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave can hold SCL low to extend any phase in which the master has released it.
  assign stretch_ok = scl_lo | scl;
  assign unused_ok  = ^{control[5:0], command[2:1]};
`else
  assign stretch_ok = 1'b1;
  assign unused_ok  = ^{control[5:0], command[2:1], scl};
`endif

  assign phase_end = (state != S_IDLE) & (cnt == '0) & stretch_ok;

  // Arbitration loss: SDA is low while this master is releasing it.
  assign lose = phase_end & ~sda &
                ((state == S_STA_B) | ((state == S_BIT_C) & c_wr & sh[7]));

  assign finish = phase_end &
                  (((state == S_STA_D) & ~c_wr & ~c_rd & ~c_sto) |
                   ((state == S_ACK_D) & ~c_sto) |
                   (state == S_STO_D));

  // Bus levels for each phase. They are registered, so all pins lag the state by one clock.
  always_comb begin
    scl_lo_n = scl_lo;
    sda_lo_n = sda_lo;
    case (state)
      S_IDLE:           if (!en) begin scl_lo_n = 1'b0; sda_lo_n = 1'b0; end
      S_STA_A:          sda_lo_n = 1'b0;   // SCL is held, so a repeated START first releases SDA
      S_STA_B:          begin scl_lo_n = 1'b0; sda_lo_n = 1'b0; end
      S_STA_C:          begin scl_lo_n = 1'b0; sda_lo_n = 1'b1; end
      S_STA_D:          begin scl_lo_n = 1'b1; sda_lo_n = 1'b1; end
      S_BIT_A, S_BIT_D: begin scl_lo_n = 1'b1; sda_lo_n = c_wr & ~sh[7]; end
      S_BIT_B, S_BIT_C: begin scl_lo_n = 1'b0; sda_lo_n = c_wr & ~sh[7]; end
      S_ACK_A, S_ACK_D: begin scl_lo_n = 1'b1; sda_lo_n = c_rd & ~c_ack; end
      S_ACK_B, S_ACK_C: begin scl_lo_n = 1'b0; sda_lo_n = c_rd & ~c_ack; end
      S_STO_A:          begin scl_lo_n = 1'b1; sda_lo_n = 1'b1; end
      S_STO_B, S_STO_C: begin scl_lo_n = 1'b0; sda_lo_n = 1'b1; end
      S_STO_D:          begin scl_lo_n = 1'b0; sda_lo_n = 1'b0; end
      default:          begin scl_lo_n = 1'b0; sda_lo_n = 1'b0; end
    endcase
  end

  always_ff @(posedge I2C_clk) begin
    if (!arst_i || abort_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      cmd_last <= '0;
      c_sto    <= 1'b0;
      c_rd     <= 1'b0;
      c_wr     <= 1'b0;
      c_ack    <= 1'b0;
      tip_reg  <= 1'b0;
      busy     <= 1'b0;
      al       <= 1'b0;
      rxack    <= 1'b0;
      if_flag  <= 1'b0;
      scl_lo   <= 1'b0;
      sda_lo   <= 1'b0;
      if (!arst_i) receive <= '0;
    end else begin
      cmd_last <= command;
      scl_lo   <= scl_lo_n;
      sda_lo   <= sda_lo_n;
      if (command[0]) if_flag <= 1'b0;

      if (!en) begin
        state   <= S_IDLE;
        tip_reg <= 1'b0;
        scl_lo  <= 1'b0;
        sda_lo  <= 1'b0;
      end else if (launch) begin
        tip_reg <= 1'b1;
        al      <= 1'b0;
        c_sto   <= command[6];
        c_wr    <= command[4];
        c_rd    <= command[5] & ~command[4];   // WR wins over RD
        c_ack   <= command[3];
        sh      <= transmit;
        bit_cnt <= '0;
        cnt     <= prescale;
        state   <= command[7] ? S_STA_A :
                   (command[5] | command[4]) ? S_BIT_A : S_STO_A;
      end else if (state != S_IDLE) begin
        if (!phase_end) begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end else begin
          cnt <= prescale;
          case (state)
            S_STA_A: state <= S_STA_B;
            S_STA_B: state <= lose ? S_IDLE : S_STA_C;
            S_STA_C: state <= S_STA_D;
            S_STA_D: begin
              busy  <= 1'b1;
              state <= (c_wr | c_rd) ? S_BIT_A : (c_sto ? S_STO_A : S_IDLE);
            end
            S_BIT_A: state <= S_BIT_B;
            S_BIT_B: state <= S_BIT_C;
            S_BIT_C: begin
              if (c_rd) sh <= {sh[6:0], sda};
              state <= lose ? S_IDLE : S_BIT_D;
            end
            S_BIT_D: begin
              if (c_wr) sh <= {sh[6:0], 1'b0};
              if (bit_cnt == 3'd7) begin
                state <= S_ACK_A;
                if (c_rd) receive <= sh;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                state   <= S_BIT_A;
              end
            end
            S_ACK_A: state <= S_ACK_B;
            S_ACK_B: state <= S_ACK_C;
            S_ACK_C: begin
              if (c_wr) rxack <= sda;
              state <= S_ACK_D;
            end
            S_ACK_D: state <= c_sto ? S_STO_A : S_IDLE;
            S_STO_A: state <= S_STO_B;
            S_STO_B: state <= S_STO_C;
            S_STO_C: state <= S_STO_D;
            S_STO_D: begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
        if (lose) begin
          al      <= 1'b1;
          busy    <= 1'b0;
          tip_reg <= 1'b0;
          scl_lo  <= 1'b0;
          sda_lo  <= 1'b0;
          if (ien) if_flag <= 1'b1;
        end
        if (finish) begin
          tip_reg <= 1'b0;
          if (ien) if_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c.sv
// -----------------------------------------------------------------------------
// tb_i2c -- bench for the i2c master. It contains a protocol-level slave on a
// pulled-up bus and a transaction-level model of status and receive.
// -----------------------------------------------------------------------------
module tb_i2c;

  logic        clk = 1'b0;
  logic        abort_i, arst_i;
  logic [15:0] prescale;
  logic [7:0]  control, transmit, command;
  wire  [7:0]  receive, status;
  wire         scl_w, sda_w;

  pullup (scl_w);
  pullup (sda_w);

  logic slave_lo;
  assign sda_w = slave_lo ? 1'b0 : 1'bz;

  i2c #(.PRESCALE_W(16)) dut (
    .I2C_clk  (clk),
    .abort_i  (abort_i),
    .arst_i   (arst_i),
    .prescale (prescale),
    .control  (control),
    .transmit (transmit),
    .receive  (receive),
    .command  (command),
    .status   (status),
    .scl      (scl_w),
    .sda      (sda_w)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard counters / model ----------------
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_busy, exp_rxack, exp_if;
  logic [7:0] exp_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {1'b0, exp_busy, 1'b0, 3'b000, exp_rxack, exp_if};
  endfunction

  // ---------------- slave model ----------------
  // It counts SCL rising edges since the last START or re-arm. On those edges it captures
  // 8 data bits and then the ACK bit. When SCL falls, it presents the next read bit or its
  // own ACK.
  logic       sl_rd, sl_sta, sl_nack;
  logic [7:0] sl_data;
  logic       arm_tog = 1'b0;
  int         rise_cnt;
  logic [7:0] cap_bits;
  logic       ack_seen;
  int         rise_t [0:9];

  initial begin
    logic arm_seen, prev_scl, prev_sda;
    arm_seen = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    slave_lo = 1'b0; rise_cnt = 0; cap_bits = '0; ack_seen = 1'b0;
    forever begin
      @(scl_w or sda_w or arm_tog);
      if (arm_tog != arm_seen) begin
        arm_seen = arm_tog;
        rise_cnt = 0;
        cap_bits = '0;
        slave_lo = (sl_rd && !sl_sta) ? ~sl_data[7] : 1'b0;
      end
      if (prev_sda && !sda_w && scl_w) begin
        rise_cnt = 0;
        cap_bits = '0;
      end
      if (!prev_scl && scl_w) begin
        if (rise_cnt < 10) rise_t[rise_cnt] = cyc;
        if (rise_cnt < 8) cap_bits = {cap_bits[6:0], sda_w};
        else if (rise_cnt == 8) ack_seen = sda_w;
        rise_cnt++;
      end
      if (prev_scl && !scl_w) begin
        if (rise_cnt < 8)       slave_lo = sl_rd ? ~sl_data[7-rise_cnt] : 1'b0;
        else if (rise_cnt == 8) slave_lo = sl_rd ? 1'b0 : ~sl_nack;
        else                    slave_lo = 1'b0;
      end
      prev_scl = scl_w;
      prev_sda = sda_w;
    end
  end

  // ---------------- driver: one command transaction ----------------
  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] tx,
                         input logic [7:0] sdata, input logic snack, input string tag);
    logic wr, rd;
    int   n;
    wr = cmd[4];
    rd = cmd[5] & ~cmd[4];
    @(negedge clk);
    sl_rd = rd; sl_sta = cmd[7]; sl_data = sdata; sl_nack = snack;
    arm_tog  = ~arm_tog;
    transmit = tx;
    command  = cmd;
    #1 check({tag, "_tip_same_cycle"}, 32'(status[7]), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (status[7] !== 1'b0 && n < 2000);
    check({tag, "_done_in_budget"}, 32'(n < 2000), 32'd1);
    if (cmd[7]) exp_busy = 1'b1;
    if (cmd[6]) exp_busy = 1'b0;
    if (wr) begin
      check({tag, "_sda_bits"}, 32'(cap_bits), 32'(tx));
      exp_rxack = snack;
    end
    if (rd) begin
      exp_rx = sdata;
      check({tag, "_master_ack_bit"}, 32'(ack_seen), 32'(cmd[3]));
    end
    if (wr || rd)
      check({tag, "_scl_period"}, 32'(rise_t[1] - rise_t[0]), 32'(4 * (int'(prescale) + 1)));
    if (control[6]) exp_if = 1'b1;
    check({tag, "_status"}, 32'(status), 32'(exp_status()));
    check({tag, "_receive"}, 32'(receive), 32'(exp_rx));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rcmd, rtx, rdat;
    logic       rrd, rnack;
    prescale = 16'd3; control = 8'hC0; transmit = '0; command = '0;
    arst_i = 1'b0; abort_i = 1'b0;
    exp_busy = 1'b0; exp_rxack = 1'b0; exp_if = 1'b0; exp_rx = '0;
    sl_rd = 1'b0; sl_sta = 1'b0; sl_nack = 1'b0; sl_data = '0;

    // Reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_status", 32'(status), 32'h00);
    check("rst_receive", 32'(receive), 32'h00);
    check("rst_scl", 32'(scl_w), 32'd1);
    check("rst_sda", 32'(sda_w), 32'd1);
    arst_i = 1'b1;

    // START + write 0x3A, slave ACKs.
    run_cmd(8'h90, 8'h3A, 8'h00, 1'b0, "wr_sta");

    // Held command must not relaunch.
    repeat (20) @(negedge clk);
    check("hold_no_relaunch", 32'(status), 32'(exp_status()));

    // Write without START.
    run_cmd(8'h10, 8'h16, 8'h00, 1'b0, "wr_nosta");

    // IACK clears IF without launching.
    @(negedge clk); command = 8'h01;
    @(negedge clk); exp_if = 1'b0;
    check("iack_clears_if", 32'(status), 32'(exp_status()));

    // Write then STOP.
    run_cmd(8'h50, 8'h05, 8'h00, 1'b0, "wr_sto");
    check("stop_scl_high", 32'(scl_w), 32'd1);
    check("stop_sda_high", 32'(sda_w), 32'd1);

    // Read with NACK.
    run_cmd(8'h28, 8'h00, 8'hA5, 1'b0, "rd_nack");

    // Disabled: no launch, and cmd_last keeps tracking command.
    @(negedge clk); control = 8'h40; command = 8'h10;
    #1 check("dis_no_tip", 32'(status[7]), 32'd0);
    repeat (3) @(negedge clk);
    control = 8'hC0;
    #1 check("reen_no_launch", 32'(status[7]), 32'd0);
    @(negedge clk); command = 8'h00;

    // Abort in the middle of a byte.
    @(negedge clk);
    sl_rd = 1'b0; sl_sta = 1'b1; sl_nack = 1'b0; arm_tog = ~arm_tog;
    transmit = 8'hC3; command = 8'h90;
    repeat (40) @(negedge clk);
    check("pre_abort_busy", 32'(status[7:6]), 32'b11);
    abort_i = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_rxack = 1'b0; exp_if = 1'b0;
    check("abort_scl", 32'(scl_w), 32'd1);
    check("abort_sda", 32'(sda_w), 32'd1);
    check("abort_status", 32'(status), 32'(exp_status()));
    check("abort_receive", 32'(receive), 32'(exp_rx));
    @(negedge clk); abort_i = 1'b0; command = 8'h00;

    // Random transactions.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      command  = 8'h00;
      prescale = 16'($urandom_range(0, 4));
      rrd   = 1'($urandom_range(0, 1));
      rcmd  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rrd, ~rrd,
               1'($urandom_range(0, 1)), 3'b000};
      rtx   = 8'($urandom);
      rdat  = 8'($urandom);
      rnack = 1'($urandom_range(0, 1));
      run_cmd(rcmd, rtx, rdat, rnack, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
